// File: rtl/sr_pkg.sv
// Shared FSM states and error codes for the SR latch driver.
package sr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PULSE = 2'b01,
      ST_DEAD  = 2'b10,
      ST_CHECK = 2'b11
   } state_e;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE    = 2'b00;
   localparam err_code_t ERR_TIMEOUT = 2'b01;
   localparam err_code_t ERR_INVALID = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, cleared to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives the s/r inputs of an external NOR SR latch with guarded pulses
// and verifies the resulting state through synchronized q/qbar feedback.
module sr_latch_driver
   import sr_pkg::*;
#(
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned DEAD_T  = 2,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic       cmd_set,
   output logic       cmd_ready,
   output logic       s,
   output logic       r,
   input  logic       q,
   input  logic       qbar,
   output logic       q_sync,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_T - 1);
   localparam logic [CNT_W-1:0] CHECK_LD = CNT_W'(TIMEOUT - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             cmd_set_q;
   logic             s_q;
   logic             r_q;
   logic             done_q;
   logic             err_q;
   err_code_t        err_code_q;
   logic             qbar_sync;

   sync_2ff u_sync_q (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (q),
      .q_o   (q_sync)
   );

   sync_2ff u_sync_qbar (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (qbar),
      .q_o   (qbar_sync)
   );

   // Command FSM with phase counter; s/r are loaded from opposite polarities
   // of one bit so they can never be high together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cmd_set_q  <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_set_q  <= cmd_set;
                  s_q        <= cmd_set;
                  r_q        <= ~cmd_set;
                  err_code_q <= ERR_NONE;
                  cnt_q      <= PULSE_LD;
                  state_q    <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (cnt_q == '0) begin
                  s_q     <= 1'b0;
                  r_q     <= 1'b0;
                  cnt_q   <= DEAD_LD;
                  state_q <= ST_DEAD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DEAD: begin
               if (cnt_q == '0) begin
                  cnt_q   <= CHECK_LD;
                  state_q <= ST_CHECK;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_CHECK: begin
               // Once q_sync != qbar_sync is known, matching q_sync alone
               // also implies qbar_sync == ~cmd_set_q
               if (q_sync == qbar_sync) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_INVALID;
                  state_q    <= ST_IDLE;
               end else if (q_sync == cmd_set_q) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (cnt_q == '0) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_TIMEOUT;
                  state_q    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               s_q     <= 1'b0;
               r_q     <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign s         = s_q;
   assign r         = r_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver driving a behavioural NOR latch.
module tb_sr_latch_driver;

   localparam int unsigned PW = 4;
   localparam int unsigned DT = 2;
   localparam int unsigned TO = 16;

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_ERR  = 2'b01;
   localparam logic [1:0] K_DONE = 2'b10;

   localparam logic [1:0] C_NONE = 2'b00;
   localparam logic [1:0] C_TO   = 2'b01;
   localparam logic [1:0] C_INV  = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_set = 1'b0;
   logic       cmd_ready;
   logic       s;
   logic       r;
   logic       q;
   logic       qbar;
   logic       q_sync;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   logic lat_q = 1'b0;
   logic force_en = 1'b0;
   logic force_q = 1'b0;
   logic force_qbar = 1'b0;

   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  kind;
      logic [1:0]  code;
      int unsigned at_edge;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   sr_latch_driver #(
      .PULSE_W (PW),
      .DEAD_T  (DT),
      .TIMEOUT (TO),
      .CNT_W   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_set   (cmd_set),
      .cmd_ready (cmd_ready),
      .s         (s),
      .r         (r),
      .q         (q),
      .qbar      (qbar),
      .q_sync    (q_sync),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Behavioural NOR latch; feedback can be overridden to model faults
   always @(s or r) begin
      if (s && !r) lat_q = 1'b1;
      else if (r && !s) lat_q = 1'b0;
   end

   assign q    = force_en ? force_q    : lat_q;
   assign qbar = force_en ? force_qbar : ~lat_q;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: s/r overlap every cycle, and every done/err against the queue
   always @(negedge clk) begin
      chk("s_r_overlap", int'(s && r), 0);
      if (rst_n && (done || err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_response", int'({done, err}), 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_kind", int'({done, err}), int'(mon_e.kind));
            chk("resp_code", int'(err_code), int'(mon_e.code));
            chk("resp_edge", int'(cyc), int'(mon_e.at_edge));
         end
      end
   end

   task automatic send(input logic set_v, input logic [1:0] kind,
                       input logic [1:0] code, output int unsigned acc);
      int unsigned n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_set   = set_v;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", int'(cmd_ready), 1);
      acc = cyc + 1;
      if (kind != K_NONE)
         exp_q.push_back('{kind, code,
                           acc + ((code == C_TO) ? (PW + DT + TO) : (PW + DT + 1))});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_set   = ~set_v;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic pulse_shape(output logic [7:0] sp, output logic [7:0] rp);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         sp[k] = s;
         rp[k] = r;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned a;
      int unsigned a_prev;
      int unsigned n;
      int unsigned budget;
      logic        flip;
      logic [7:0]  sp;
      logic [7:0]  rp;

      #2;
      chk("rst_s", int'(s), 0);
      chk("rst_r", int'(r), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_q_sync", int'(q_sync), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", int'(cmd_ready), 1);

      // Set command on a latch holding 0
      send(1'b1, K_DONE, C_NONE, a);
      pulse_shape(sp, rp);
      chk("set_s_shape", int'(sp), 8'h0F);
      chk("set_r_shape", int'(rp), 0);
      drain();
      chk("set_latch_q", int'(q), 1);
      chk("set_q_sync", int'(q_sync), 1);

      // Reset command
      send(1'b0, K_DONE, C_NONE, a);
      pulse_shape(sp, rp);
      chk("rst_cmd_s_shape", int'(sp), 0);
      chk("rst_cmd_r_shape", int'(rp), 8'h0F);
      drain();
      chk("rst_cmd_latch_q", int'(q), 0);
      chk("rst_cmd_q_sync", int'(q_sync), 0);

      // Feedback stuck at q=0: timeout after all CHECK cycles
      force_en = 1'b1; force_q = 1'b0; force_qbar = 1'b1;
      send(1'b1, K_ERR, C_TO, a);
      drain();
      repeat (3) @(negedge clk);
      chk("timeout_code_held", int'(err_code), int'(C_TO));
      chk("timeout_ready", int'(cmd_ready), 1);
      force_en = 1'b0;

      // Feedback q=qbar=1: invalid on the first CHECK cycle
      force_en = 1'b1; force_q = 1'b1; force_qbar = 1'b1;
      send(1'b0, K_ERR, C_INV, a);
      drain();
      force_en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted mid-PULSE: command discarded silently
      send(1'b1, K_NONE, C_NONE, a);
      @(negedge clk);
      @(negedge clk);
      chk("midpulse_s_before", int'(s), 1);
      rst_n = 1'b0;
      #1;
      chk("midpulse_s_async", int'(s), 0);
      chk("midpulse_r_async", int'(r), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midpulse_ready", int'(cmd_ready), 1);
      chk("midpulse_err_code", int'(err_code), 0);
      repeat (10) @(negedge clk);
      send(1'b0, K_DONE, C_NONE, a);
      drain();
      chk("post_reset_q_sync", int'(q_sync), 0);

      // cmd_valid held with alternating cmd_set: accepts land in done cycles
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_set   = 1'b1;
      n = 0; budget = 0; flip = 1'b0; a_prev = 0;
      while (n < 4 && budget < 200) begin
         if (n > 0 && cyc == a_prev + 3)
            chk("busy_not_ready", int'(cmd_ready), 0);
         if (cmd_ready) begin
            a = cyc + 1;
            if (n > 0) chk("b2b_gap", int'(a - a_prev), int'(PW + DT + 2));
            exp_q.push_back('{K_DONE, C_NONE, a + PW + DT + 1});
            a_prev = a;
            n++;
            flip = 1'b1;
         end else if (flip) begin
            cmd_set = ~cmd_set;
            flip    = 1'b0;
         end
         @(negedge clk);
         budget++;
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", int'(n), 4);
      drain();
      chk("b2b_final_q_sync", int'(q_sync), 0);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
